// File: rtl/mcds_pkg.sv
// Shared constants and types for the multi-channel data synchronizer.
// Imported by mcds_channel and multi_channel_data_synchronizer.
package mcds_pkg;

    localparam int PULSE_MODE_LEVEL  = 0;
    localparam int PULSE_MODE_TOGGLE = 1;
    localparam int MIN_STAGES        = 2;
    localparam int MAX_STAGES        = 4;
    localparam int MAX_CHANNELS      = 8;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/mcds_channel.sv
// One channel: enable synchronizer chain, edge detect, held data word,
// valid/ready handshake and sticky overflow flag.
// Optional macro MCDS_ACK_TOGGLE_EN adds o_ack_toggle.
// Ports:
//   clk, reset_n       destination clock, async active-low reset
//   i_enable           unsynchronized enable / toggle line
//   i_data             source word, stable while the enable is in flight
//   i_ready            consumer accepts the held word
//   i_clear_overflow   synchronous clear of the overflow flag
//   o_enable_pulse     one-cycle pulse in the cycle a word lands
//   o_valid            word held and not yet accepted
//   o_data             captured word
//   o_overflow         sticky: a held word was overwritten unaccepted
//   o_ack_toggle       (macro only) toggles on every accept
module mcds_channel
    import mcds_pkg::*;
#(
    parameter int NUM_OF_STAGES = 3,
    parameter int BUS_WIDTH     = 8,
    parameter int PULSE_MODE    = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_enable,
    input  logic [BUS_WIDTH-1:0] i_data,
    input  logic                 i_ready,
    input  logic                 i_clear_overflow,
    output logic                 o_enable_pulse,
    output logic                 o_valid,
    output logic [BUS_WIDTH-1:0] o_data,
`ifdef MCDS_ACK_TOGGLE_EN
    output logic                 o_ack_toggle,
`endif
    output logic                 o_overflow
);

    logic [NUM_OF_STAGES-1:0] r_sync;
    logic                     r_prev;
    logic [BUS_WIDTH-1:0]     r_data;
    logic                     r_pulse;
    logic                     r_overflow;
    ch_state_e                r_state;
    ch_state_e                w_state_nxt;
    logic                     w_sync;
    logic                     w_qualify;
    logic                     w_accept;
    logic                     w_ovf_set;

    assign w_sync = r_sync[NUM_OF_STAGES-1];

    // Toggle mode treats either edge as a new word; level mode only rising.
    assign w_qualify = (PULSE_MODE == PULSE_MODE_TOGGLE) ?
                       (w_sync ^ r_prev) : (w_sync & ~r_prev);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[NUM_OF_STAGES-2:0], i_enable};
            r_prev <= w_sync;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ovf_set   = 1'b0;
        unique case (r_state)
            CH_EMPTY: begin
                if (w_qualify) w_state_nxt = CH_FULL;
            end
            CH_FULL: begin
                w_accept  = i_ready;
                // A new word arriving while the old one is unaccepted is lost data.
                w_ovf_set = w_qualify & ~i_ready;
                if (i_ready && !w_qualify) w_state_nxt = CH_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= CH_EMPTY;
            r_data     <= '0;
            r_pulse    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pulse <= w_qualify;
            if (w_qualify) r_data <= i_data;
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (i_clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef MCDS_ACK_TOGGLE_EN
    logic r_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack <= 1'b0;
        end else if (w_accept) begin
            r_ack <= ~r_ack;
        end
    end

    assign o_ack_toggle = r_ack;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif

    assign o_enable_pulse = r_pulse;
    assign o_valid        = (r_state == CH_FULL);
    assign o_data         = r_data;
    assign o_overflow     = r_overflow;

endmodule

// File: rtl/multi_channel_data_synchronizer.sv
// Multi-channel enable-qualified synchronizer in the destination domain.
// Optional macro MCDS_ACK_TOGGLE_EN adds ack_toggle_out.
// Ports (NC = NUM_CHANNELS, W = BUS_WIDTH):
//   clk, reset_n            destination clock, async active-low reset
//   bus_enable_in[NC]       unsynchronized per-channel enable/toggle
//   unsync_data_in[NC*W]    channel c at [c*W +: W]
//   ready_in[NC]            consumer accept
//   clear_overflow_in[NC]   synchronous overflow clear
//   enable_pulse_out[NC]    one-cycle load pulse
//   sync_valid_out[NC]      word held, not yet accepted
//   sync_data_out[NC*W]     captured words, same packing
//   overflow_out[NC]        sticky overwrite flag
//   ack_toggle_out[NC]      (macro only) toggles on each accept
module multi_channel_data_synchronizer
    import mcds_pkg::*;
#(
    parameter int NUM_OF_STAGES = 3,
    parameter int BUS_WIDTH     = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int PULSE_MODE    = 0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_CHANNELS-1:0]           bus_enable_in,
    input  logic [NUM_CHANNELS*BUS_WIDTH-1:0] unsync_data_in,
    input  logic [NUM_CHANNELS-1:0]           ready_in,
    input  logic [NUM_CHANNELS-1:0]           clear_overflow_in,
    output logic [NUM_CHANNELS-1:0]           enable_pulse_out,
    output logic [NUM_CHANNELS-1:0]           sync_valid_out,
    output logic [NUM_CHANNELS*BUS_WIDTH-1:0] sync_data_out,
`ifdef MCDS_ACK_TOGGLE_EN
    output logic [NUM_CHANNELS-1:0]           ack_toggle_out,
`endif
    output logic [NUM_CHANNELS-1:0]           overflow_out
);

    if (NUM_OF_STAGES < MIN_STAGES || NUM_OF_STAGES > MAX_STAGES) begin : g_bad_stages
        $error("NUM_OF_STAGES out of range 2..4");
    end
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("NUM_CHANNELS out of range 1..8");
    end
    if (PULSE_MODE != PULSE_MODE_LEVEL && PULSE_MODE != PULSE_MODE_TOGGLE) begin : g_bad_mode
        $error("PULSE_MODE must be 0 or 1");
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("BUS_WIDTH must be at least 1");
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        mcds_channel #(
            .NUM_OF_STAGES (NUM_OF_STAGES),
            .BUS_WIDTH     (BUS_WIDTH),
            .PULSE_MODE    (PULSE_MODE)
        ) u_ch (
            .clk              (clk),
            .reset_n          (reset_n),
            .i_enable         (bus_enable_in[g]),
            .i_data           (unsync_data_in[g*BUS_WIDTH +: BUS_WIDTH]),
            .i_ready          (ready_in[g]),
            .i_clear_overflow (clear_overflow_in[g]),
            .o_enable_pulse   (enable_pulse_out[g]),
            .o_valid          (sync_valid_out[g]),
            .o_data           (sync_data_out[g*BUS_WIDTH +: BUS_WIDTH]),
`ifdef MCDS_ACK_TOGGLE_EN
            .o_ack_toggle     (ack_toggle_out[g]),
`endif
            .o_overflow       (overflow_out[g])
        );
    end

endmodule

// File: tb/tb_multi_channel_data_synchronizer.sv
// Scoreboard bench: a level-mode and a toggle-mode instance, each with
// two channels, driven by directed then random stimulus.
module tb_multi_channel_data_synchronizer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  en    [2];
    logic [15:0] dat   [2];
    logic [1:0]  rdy   [2];
    logic [1:0]  clr   [2];
    logic [1:0]  pulse [2];
    logic [1:0]  valid [2];
    logic [15:0] sdata [2];
    logic [1:0]  ovf   [2];
`ifdef MCDS_ACK_TOGGLE_EN
    logic [1:0]  ack   [2];
`endif

    typedef struct {
        int         d;
        int         c;
        int         e;
        logic [7:0] data;
    } ev_t;

    ev_t        q[$];
    int         edge_n = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         last_chg [2][2];
    bit         v_m [2][2];
    bit         o_m [2][2];
    bit         p_m [2][2];
    bit         a_m [2][2];
    logic [7:0] d_m [2][2];

    multi_channel_data_synchronizer #(
        .NUM_OF_STAGES(3), .BUS_WIDTH(8), .NUM_CHANNELS(2), .PULSE_MODE(0)
    ) u_lvl (
        .clk               (clk),
        .reset_n           (reset_n),
        .bus_enable_in     (en[0]),
        .unsync_data_in    (dat[0]),
        .ready_in          (rdy[0]),
        .clear_overflow_in (clr[0]),
        .enable_pulse_out  (pulse[0]),
        .sync_valid_out    (valid[0]),
        .sync_data_out     (sdata[0]),
`ifdef MCDS_ACK_TOGGLE_EN
        .ack_toggle_out    (ack[0]),
`endif
        .overflow_out      (ovf[0])
    );

    multi_channel_data_synchronizer #(
        .NUM_OF_STAGES(3), .BUS_WIDTH(8), .NUM_CHANNELS(2), .PULSE_MODE(1)
    ) u_tog (
        .clk               (clk),
        .reset_n           (reset_n),
        .bus_enable_in     (en[1]),
        .unsync_data_in    (dat[1]),
        .ready_in          (rdy[1]),
        .clear_overflow_in (clr[1]),
        .enable_pulse_out  (pulse[1]),
        .sync_valid_out    (valid[1]),
        .sync_data_out     (sdata[1]),
`ifdef MCDS_ACK_TOGGLE_EN
        .ack_toggle_out    (ack[1]),
`endif
        .overflow_out      (ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int d, int c,
                                logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d ch%0d edge %0d: got %0h expected %0h",
                     name, d, c, edge_n, act, exp);
        end
    endfunction

    function automatic void clear_model();
        q.delete();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                v_m[d][c] = 1'b0;
                o_m[d][c] = 1'b0;
                p_m[d][c] = 1'b0;
                a_m[d][c] = 1'b0;
                d_m[d][c] = 8'h00;
            end
        end
    endfunction

    function automatic void check_all_zero(string name);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                chk({name, "_valid"}, d, c, 32'(valid[d][c]), 32'd0);
                chk({name, "_pulse"}, d, c, 32'(pulse[d][c]), 32'd0);
                chk({name, "_data"},  d, c, 32'(sdata[d][c*8 +: 8]), 32'd0);
                chk({name, "_ovf"},   d, c, 32'(ovf[d][c]), 32'd0);
`ifdef MCDS_ACK_TOGGLE_EN
                chk({name, "_ack"},   d, c, 32'(ack[d][c]), 32'd0);
`endif
            end
        end
    endfunction

    // Level mode captures on a rising enable, toggle mode on any change;
    // the word lands on the fourth edge after the change is driven.
    task automatic set_en(int d, int c, bit lvl, logic [7:0] v);
        bit sched;
        sched = (d == 0) ? (lvl && !en[d][c]) : (lvl != en[d][c]);
        if (sched) begin
            dat[d][c*8 +: 8] = v;
            if (reset_n) q.push_back('{d, c, edge_n + 4, v});
        end
        en[d][c] = lvl;
        last_chg[d][c] = edge_n;
    endtask

    task automatic step(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Monitor / reference model.
    initial begin
        bit         land;
        bit         oset;
        bit         vo;
        logic [7:0] nd;
        forever begin
            @(posedge clk);
            edge_n++;
            if (reset_n) begin
                for (int d = 0; d < 2; d++) begin
                    for (int c = 0; c < 2; c++) begin
                        land = 1'b0;
                        oset = 1'b0;
                        nd   = 8'h00;
                        for (int i = 0; i < q.size(); i++) begin
                            if (q[i].d == d && q[i].c == c && q[i].e == edge_n) begin
                                land = 1'b1;
                                nd   = q[i].data;
                                q.delete(i);
                                break;
                            end
                        end
                        vo = v_m[d][c];
                        if (vo && rdy[d][c]) a_m[d][c] = ~a_m[d][c];
                        if (land) begin
                            oset      = vo && !rdy[d][c];
                            v_m[d][c] = 1'b1;
                            d_m[d][c] = nd;
                            p_m[d][c] = 1'b1;
                        end else begin
                            p_m[d][c] = 1'b0;
                            if (vo && rdy[d][c]) v_m[d][c] = 1'b0;
                        end
                        if (oset) o_m[d][c] = 1'b1;
                        else if (clr[d][c]) o_m[d][c] = 1'b0;
                    end
                end
            end
            #1;
            if (reset_n) begin
                for (int d = 0; d < 2; d++) begin
                    for (int c = 0; c < 2; c++) begin
                        chk("valid", d, c, 32'(valid[d][c]), 32'(v_m[d][c]));
                        chk("pulse", d, c, 32'(pulse[d][c]), 32'(p_m[d][c]));
                        chk("data",  d, c, 32'(sdata[d][c*8 +: 8]), 32'(d_m[d][c]));
                        chk("ovf",   d, c, 32'(ovf[d][c]), 32'(o_m[d][c]));
`ifdef MCDS_ACK_TOGGLE_EN
                        chk("ack",   d, c, 32'(ack[d][c]), 32'(a_m[d][c]));
`endif
                    end
                end
            end
        end
    end

    // Driver.
    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            en[d]  = '0;
            dat[d] = '0;
            rdy[d] = '0;
            clr[d] = '0;
            for (int c = 0; c < 2; c++) last_chg[d][c] = 0;
        end
        clear_model();
        #3;
        check_all_zero("reset");
        step(2);
        reset_n = 1'b1;
        step(2);

        // Level capture, then hold, then accept.
        set_en(0, 0, 1'b1, 8'hA5);
        step(14);
        rdy[0][0] = 1'b1;
        step();
        rdy[0][0] = 1'b0;

        // Overwrite without accept sets overflow; clear drops it.
        set_en(0, 0, 1'b0, 8'h00);
        step(4);
        set_en(0, 0, 1'b1, 8'h11);
        step(4);
        set_en(0, 0, 1'b0, 8'h00);
        step(4);
        set_en(0, 0, 1'b1, 8'h22);
        step(6);
        clr[0][0] = 1'b1;
        step();
        clr[0][0] = 1'b0;
        rdy[0][0] = 1'b1;
        step();
        rdy[0][0] = 1'b0;

        // Accept in the same cycle as a new load: no overflow.
        set_en(0, 0, 1'b0, 8'h00);
        step(4);
        set_en(0, 0, 1'b1, 8'h33);
        step(4);
        set_en(0, 0, 1'b0, 8'h00);
        step(4);
        set_en(0, 0, 1'b1, 8'h44);
        step(3);
        rdy[0][0] = 1'b1;
        step();
        rdy[0][0] = 1'b0;
        step(2);

        // Toggle mode: both edges capture.
        set_en(1, 0, 1'b1, 8'h5A);
        step(5);
        rdy[1][0] = 1'b1;
        step();
        rdy[1][0] = 1'b0;
        set_en(1, 0, 1'b0, 8'hC3);
        step(5);
        rdy[1][0] = 1'b1;
        step();
        rdy[1][0] = 1'b0;

        // Reset one cycle after an enable rises; re-detected after release.
        set_en(0, 0, 1'b0, 8'h00);
        step(4);
        set_en(0, 0, 1'b1, 8'h77);
        step();
        reset_n = 1'b0;
        clear_model();
        #1;
        check_all_zero("midreset");
        en[1] = '0;
        step(2);
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if (en[0][c]) q.push_back('{0, c, edge_n + 4, dat[0][c*8 +: 8]});
            last_chg[0][c] = edge_n;
            last_chg[1][c] = edge_n;
        end
        step(6);

        // Random traffic on all channels.
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 2; c++) begin
                    rdy[d][c] = ($urandom_range(0, 2) == 0);
                    clr[d][c] = ($urandom_range(0, 7) == 0);
                    if (edge_n - last_chg[d][c] >= 4 && $urandom_range(0, 2) == 0)
                        set_en(d, c, ~en[d][c], 8'($urandom));
                end
            end
            step();
        end

        // Drain: every scheduled word must have landed.
        for (int d = 0; d < 2; d++) begin
            rdy[d] = '1;
            clr[d] = '0;
        end
        step(8);
        chk("drain_pending", 0, 0, 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_channel_data_synchronizer.md
Name: multi_channel_data_synchronizer

Overview:
Parametrised successor to the single-bus enable-qualified synchronizer, clocked entirely in the destination domain. It supports NUM_CHANNELS independent buses, each qualified by its own enable signal from the source domain. The enable can be level-style (rising edge qualifies) or toggle-style (any edge qualifies). Captured words are held valid until the consumer accepts them with a valid/ready handshake, and a sticky overflow flag records any word overwritten before it was accepted.

Parameters:
NUM_OF_STAGES, 3, synchronizer flops per enable line; legal range 2..4.
BUS_WIDTH, 8, data bits per channel.
NUM_CHANNELS, 2, independent channels; legal range 1..8.
PULSE_MODE, 0, 0 = level mode (rising edge qualifies), 1 = toggle mode (any edge qualifies); applies to all channels.

Ports:
clk  input  1  destination-domain clock
reset_n  input  1  asynchronous active-low reset
bus_enable_in  input  NUM_CHANNELS  unsynchronized per-channel enable/toggle
unsync_data_in  input  NUM_CHANNELS*BUS_WIDTH  per-channel data; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH]; source keeps it stable while the enable is in flight
ready_in  input  NUM_CHANNELS  consumer accepts the channel word this cycle
clear_overflow_in  input  NUM_CHANNELS  synchronous clear of the sticky overflow flag
enable_pulse_out  output  NUM_CHANNELS  one-cycle pulse, asserted in the cycle new data lands
sync_valid_out  output  NUM_CHANNELS  channel word is held and not yet accepted
sync_data_out  output  NUM_CHANNELS*BUS_WIDTH  captured data, same packing as unsync_data_in
overflow_out  output  NUM_CHANNELS  sticky: a captured word was overwritten before acceptance

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n). Reset clears all synchronizer flops, edge flops, enable_pulse_out, sync_valid_out, sync_data_out and overflow_out to 0.
- Per channel, bus_enable_in[c] passes through NUM_OF_STAGES flops, then one edge flop (prev).
- qualify is combinational:
  - PULSE_MODE=0: qualify = sync & ~prev.
  - PULSE_MODE=1: qualify = sync ^ prev.
- Latency: if edge k first samples the new enable level, qualify is high in the cycle after edge k+NUM_OF_STAGES-1. At edge k+NUM_OF_STAGES, sync_data_out is loaded, sync_valid_out=1 and enable_pulse_out=1 (pulse lasts one cycle). Default: 3 edges.
- Per-channel state (implicit FSM): EMPTY (valid=0), FULL (valid=1).
  - EMPTY, qualify -> FULL, data loaded.
  - FULL, ready_in and not qualify -> EMPTY; data register holds its last value.
  - FULL, ready_in and qualify -> stays FULL, new data loaded, no overflow.
  - FULL, qualify and not ready_in -> stays FULL, data overwritten, overflow_out set.
  - EMPTY, ready_in -> ignored.
- overflow_out:
  - Set and clear in the same cycle: set wins.
  - Otherwise clear_overflow_in clears it at the next edge.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset mid-transfer: in-flight enables are discarded. In level mode, an enable still high after reset is re-detected as a rising edge. In toggle mode the toggle state is lost; the source must re-toggle.
- enable_pulse_out rises with every load, including overwrites.

Optional Feature:
Macro MCDS_ACK_TOGGLE_EN.
- Defined: adds output ack_toggle_out[NUM_CHANNELS], reset 0. It toggles at the edge where a FULL channel is accepted (valid & ready), for a return-path synchronizer back to the source domain.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package mcds_pkg holds: PULSE_MODE_LEVEL=0, PULSE_MODE_TOGGLE=1, MIN_STAGES=2, MAX_STAGES=4, MAX_CHANNELS=8.
- One sub-module, mcds_channel: the stage chain, edge flop, qualify logic, data/valid/overflow registers (and the ack toggle when enabled) for one channel.
- The top level generates NUM_CHANNELS instances and slices the buses. It also checks parameter legality during elaboration.

Test Plan:
- Reset, level mode, NUM_OF_STAGES=3: set bus_enable_in[0]=1 with data 0xA5 -> sync_valid_out[0]=1, sync_data_out[7:0]=0xA5, one-cycle enable_pulse_out[0], all 3 edges after the first sampling edge; channel 1 unaffected.
- Hold valid, ready_in[0]=0 for 10 cycles -> data 0xA5 and valid stay stable. Pulse ready_in[0] for 1 cycle -> valid=0 next edge.
- Overflow: capture 0x11, no ready, second qualified edge with 0x22 -> data=0x22, valid=1, overflow_out[0]=1. Set clear_overflow_in[0]=1 for 1 cycle -> overflow_out[0]=0.
- Same-cycle accept and new capture (ready=1 in the cycle qualify=1): data 0x33 then 0x44 -> valid stays 1, data=0x44, overflow=0.
- Toggle mode (PULSE_MODE=1): toggle enable 0->1->0 with data 0x5A then 0xC3, accepting between toggles -> two captures, values 0x5A then 0xC3.
- Assert reset_n=0 mid-flight, 1 cycle after the enable rises -> all outputs 0 immediately. Release reset with the enable still high in level mode -> capture occurs 3 edges after release.
